// File: rtl/bpred_table.sv
// ---------------------------------------------------------------------------
// bpred_table
//   Branch prediction table of 2^IDX_W saturating counters. The table can be
//   indexed bimodally (MODE=0) or by gshare (MODE=1, address XOR global
//   history). After reset the table walks through every entry and writes
//   weakly-not-taken into it. It then serves a pipelined predict port with a
//   1-cycle latency and an independent resolve/update port.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   pred_valid  predict request
//   pred_addr   branch address for prediction             [ADDR_W]
//   pred_ready  table initialised, requests are accepted
//   resp_valid  1-cycle pulse, one per accepted request
//   resp_taken  predicted direction (counter MSB)
//   resp_ctr    counter value used for the prediction      [CTR_W]
//   resp_idx    table index used; returned later on update [IDX_W]
//   upd_valid   outcome update strobe
//   upd_idx     entry to update                            [IDX_W]
//   upd_taken   actual branch outcome
//   ghr         current global history register            [HIST_W]
// ---------------------------------------------------------------------------
module bpred_table #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 10,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 8,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_addr,
    output logic              pred_ready,
    output logic              resp_valid,
    output logic              resp_taken,
    output logic [CTR_W-1:0]  resp_ctr,
    output logic [IDX_W-1:0]  resp_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    output logic [HIST_W-1:0] ghr
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   init_ptr;
    logic [CTR_W-1:0]   table_q [DEPTH];

    logic               pred_fire;
    logic               upd_fire;
    logic [IDX_W-1:0]   pred_idx;
    logic [CTR_W-1:0]   upd_old;
    logic [CTR_W-1:0]   upd_new;
    logic [HIST_W-1:0]  ghr_shift;

    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [CTR_W-1:0]   wdata;

    // Only the low IDX_W address bits select an entry; the rest are ignored.
    logic               addr_unused;
    assign addr_unused = ^pred_addr;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state <= state_next;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + IDX_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_next = state;
        pred_ready = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_ptr == '1) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                pred_ready = 1'b1;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Both ports are dead until initialisation has finished.
    assign pred_fire = pred_valid && pred_ready;
    assign upd_fire  = upd_valid && pred_ready;

    // ------------------------------------------------------------------
    // Index computation (uses the history value before this edge's update)
    // ------------------------------------------------------------------
    generate
        if (MODE == 1) begin : g_gshare
            logic [IDX_W-1:0] ghr_ext;
            always_comb begin
                ghr_ext              = '0;
                ghr_ext[HIST_W-1:0]  = ghr;
            end
            assign pred_idx = pred_addr[IDX_W-1:0] ^ ghr_ext;
        end else begin : g_bimodal
            assign pred_idx = pred_addr[IDX_W-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturating counter update and history shift
    // ------------------------------------------------------------------
    assign upd_old = table_q[upd_idx];

    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != '1) upd_new = upd_old + CTR_W'(1);
        end else begin
            if (upd_old != '0) upd_new = upd_old - CTR_W'(1);
        end
    end

    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift = upd_taken;
        end else begin : g_histn
            assign ghr_shift = {ghr[HIST_W-2:0], upd_taken};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Single write port: init pointer in INIT, update port in READY
    // ------------------------------------------------------------------
    always_comb begin
        we    = 1'b0;
        waddr = upd_idx;
        wdata = upd_new;
        if (state == ST_INIT) begin
            we    = rst_n;
            waddr = init_ptr;
            wdata = CTR_WNT;
        end else if (upd_fire) begin
            we    = rst_n;
        end
    end

    // NOTE: the table array has no reset; the INIT sweep gives it defined
    // contents, which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            table_q[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline and global history
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_ctr   <= '0;
            resp_idx   <= '0;
            ghr        <= '0;
        end else begin
            resp_valid <= pred_fire;
            if (pred_fire) begin
                // Write-first bypass: a same-edge update to this entry is
                // visible in the response.
                if (upd_fire && (upd_idx == pred_idx)) begin
                    resp_ctr   <= upd_new;
                    resp_taken <= upd_new[CTR_W-1];
                end else begin
                    resp_ctr   <= table_q[pred_idx];
                    resp_taken <= table_q[pred_idx][CTR_W-1];
                end
                resp_idx <= pred_idx;
            end
            if (upd_fire) begin
                ghr <= ghr_shift;
            end
        end
    end

endmodule

// File: tb/tb_bpred_table.sv
// ---------------------------------------------------------------------------
// tb_bpred_table
//   Directed bench for bpred_table with two instances sharing stimulus:
//   b_* is bimodal, g_* is gshare (both IDX_W=4, HIST_W=4, CTR_W=2).
// ---------------------------------------------------------------------------
module tb_bpred_table;

    localparam int ADDR_W = 8;
    localparam int IDX_W  = 4;
    localparam int CTR_W  = 2;
    localparam int HIST_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pred_valid = 1'b0;
    logic [ADDR_W-1:0] pred_addr = '0;
    logic              upd_valid = 1'b0;
    logic [IDX_W-1:0]  upd_idx = '0;
    logic              upd_taken = 1'b0;

    logic              b_pred_ready, b_resp_valid, b_resp_taken;
    logic [CTR_W-1:0]  b_resp_ctr;
    logic [IDX_W-1:0]  b_resp_idx;
    logic [HIST_W-1:0] b_ghr;
    logic              g_pred_ready, g_resp_valid, g_resp_taken;
    logic [CTR_W-1:0]  g_resp_ctr;
    logic [IDX_W-1:0]  g_resp_idx;
    logic [HIST_W-1:0] g_ghr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpred_table #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_addr(pred_addr),
        .pred_ready(b_pred_ready), .resp_valid(b_resp_valid), .resp_taken(b_resp_taken),
        .resp_ctr(b_resp_ctr), .resp_idx(b_resp_idx), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_taken(upd_taken), .ghr(b_ghr)
    );

    bpred_table #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .MODE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_addr(pred_addr),
        .pred_ready(g_pred_ready), .resp_valid(g_resp_valid), .resp_taken(g_resp_taken),
        .resp_ctr(g_resp_ctr), .resp_idx(g_resp_idx), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_taken(upd_taken), .ghr(g_ghr)
    );

    typedef struct {
        logic              pv;
        logic [ADDR_W-1:0] addr;
        logic              uv;
        logic [IDX_W-1:0]  uidx;
        logic              ut;
        logic              exp_rv;
        logic [CTR_W-1:0]  exp_ctr;
        logic              exp_taken;
        logic [IDX_W-1:0]  exp_idx;
        logic [HIST_W-1:0] exp_ghr;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at a negedge and return at the next one.
    task automatic step(input logic pv, input logic [ADDR_W-1:0] addr,
                        input logic uv, input logic [IDX_W-1:0] uidx, input logic ut);
        pred_valid = pv;
        pred_addr  = addr;
        upd_valid  = uv;
        upd_idx    = uidx;
        upd_taken  = ut;
        @(negedge clk);
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    // Hold reset across one edge, check reset outputs, then release.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        @(negedge clk);
        check({name, "_rst_valid"}, b_resp_valid, 0);
        check({name, "_rst_ctr"},   b_resp_ctr, 0);
        check({name, "_rst_idx"},   b_resp_idx, 0);
        check({name, "_rst_ghr"},   b_ghr, 0);
        check({name, "_rst_ready"}, b_pred_ready, 0);
        rst_n = 1'b1;
    endtask

    // Count cycles with pred_ready low (bounded); optionally pulse both
    // request strobes to confirm they are ignored during INIT.
    task automatic wait_ready(input string name, input bit noise);
        int n = 0;
        int bad = 0;
        while (!b_pred_ready && n < 100) begin
            if (noise) begin
                step(1'b1, ADDR_W'(n), 1'b1, IDX_W'(n), 1'b1);
                if (b_resp_valid || g_resp_valid || b_ghr != 0 || g_ghr != 0) bad++;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        check({name, "_init_cycles"}, n, 16);
        check({name, "_g_ready"}, g_pred_ready, 1);
        if (noise) check({name, "_init_ignored"}, bad, 0);
    endtask

    initial begin
        @(negedge clk);

        // ---------------- init timing + requests ignored in INIT ----------
        do_reset("init");
        wait_ready("init", 1'b1);
        check("init_ghr", b_ghr, 0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, ADDR_W'(i), 1'b0, '0, 1'b0);
            check($sformatf("init_wnt_valid_%0d", i), b_resp_valid, 1);
            check($sformatf("init_wnt_ctr_%0d", i), b_resp_ctr, 2'b01);
        end

        // ---------------- bimodal vector table (fresh table, ghr=0) -------
        do_reset("tbl");
        wait_ready("tbl", 1'b0);
        //          pv    addr   uv  uidx ut   rv  ctr   tk  idx  ghr
        vecs[0]  = '{1'b1, 8'h03, 1'b0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b0, 4'h3, 4'h0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0, 4'h3, 4'h1};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0, 4'h3, 4'h3};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0, 4'h3, 4'h7};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b1, 1'b0, 2'b01, 1'b0, 4'h3, 4'hF};
        vecs[5]  = '{1'b1, 8'h05, 1'b0, 4'h0, 1'b0, 1'b1, 2'b11, 1'b1, 4'h5, 4'hF};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 2'b11, 1'b1, 4'h5, 4'hE};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 2'b11, 1'b1, 4'h5, 4'hC};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 2'b11, 1'b1, 4'h5, 4'h8};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 2'b11, 1'b1, 4'h5, 4'h0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 4'h5, 1'b0, 1'b0, 2'b11, 1'b1, 4'h5, 4'h0};
        vecs[11] = '{1'b1, 8'h15, 1'b0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h5, 4'h0};
        vecs[12] = '{1'b1, 8'h07, 1'b1, 4'h7, 1'b1, 1'b1, 2'b10, 1'b1, 4'h7, 4'h1};
        vecs[13] = '{1'b1, 8'h07, 1'b0, 4'h0, 1'b0, 1'b1, 2'b10, 1'b1, 4'h7, 4'h1};
        vecs[14] = '{1'b1, 8'h05, 1'b1, 4'h7, 1'b0, 1'b1, 2'b00, 1'b0, 4'h5, 4'h2};
        vecs[15] = '{1'b1, 8'h07, 1'b0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b0, 4'h7, 4'h2};
        vecs[16] = '{1'b1, 8'h05, 1'b1, 4'h5, 1'b0, 1'b1, 2'b00, 1'b0, 4'h5, 4'h4};
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].pv, vecs[i].addr, vecs[i].uv, vecs[i].uidx, vecs[i].ut);
            check($sformatf("vec%0d_valid", i), b_resp_valid, vecs[i].exp_rv);
            check($sformatf("vec%0d_ctr", i),   b_resp_ctr,   vecs[i].exp_ctr);
            check($sformatf("vec%0d_taken", i), b_resp_taken, vecs[i].exp_taken);
            check($sformatf("vec%0d_idx", i),   b_resp_idx,   vecs[i].exp_idx);
            check($sformatf("vec%0d_ghr", i),   b_ghr,        vecs[i].exp_ghr);
        end

        // ---------------- gshare indexing -------------------------------
        do_reset("gsh");
        wait_ready("gsh", 1'b0);
        step(1'b0, '0, 1'b1, 4'h0, 1'b1);
        step(1'b0, '0, 1'b1, 4'h0, 1'b1);
        step(1'b0, '0, 1'b1, 4'h0, 1'b0);
        check("gsh_ghr", g_ghr, 4'b0110);
        step(1'b1, 8'h00, 1'b0, '0, 1'b0);
        check("gsh_a0_valid", g_resp_valid, 1);
        check("gsh_a0_idx", g_resp_idx, 4'h6);
        check("gsh_a0_ctr", g_resp_ctr, 2'b01);
        check("bim_a0_idx", b_resp_idx, 4'h0);
        check("bim_a0_ctr", b_resp_ctr, 2'b10);
        step(1'b1, 8'h06, 1'b0, '0, 1'b0);
        check("gsh_a6_idx", g_resp_idx, 4'h0);
        check("gsh_a6_ctr", g_resp_ctr, 2'b10);
        check("gsh_a6_taken", g_resp_taken, 1);

        // ---------------- reset mid-operation ---------------------------
        step(1'b0, '0, 1'b1, 4'h2, 1'b1);
        step(1'b0, '0, 1'b1, 4'h2, 1'b1);
        step(1'b1, 8'h02, 1'b0, '0, 1'b0);
        check("mid_pre_ctr", b_resp_ctr, 2'b11);
        pred_valid = 1'b1;
        pred_addr  = 8'h02;
        do_reset("mid");
        pred_valid = 1'b0;
        wait_ready("mid", 1'b0);
        step(1'b1, 8'h02, 1'b0, '0, 1'b0);
        check("mid_post_valid", b_resp_valid, 1);
        check("mid_post_ctr", b_resp_ctr, 2'b01);
        step(1'b0, '0, 1'b0, '0, 1'b0);
        check("mid_pulse_end", b_resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
